// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared constants and helpers for the pipelined carry-lookahead adder.
//   CLA_WIDTH  : default operand width in bits
//   CLA_BLK    : default lookahead block width (one block per pipeline stage)
//   claStages  : number of register stages for a given width/block split
// ---------------------------------------------------------------------------
package cla_pkg;

  localparam int CLA_WIDTH = 16;
  localparam int CLA_BLK   = 4;

  // One operand-capture stage plus one stage per lookahead block.
  function automatic int claStages(input int width, input int blk);
    return (width / blk) + 1;
  endfunction

endpackage

// File: rtl/cla_block.sv
// ---------------------------------------------------------------------------
// cla_block
// Purely combinational BLK-bit carry-lookahead adder slice.
//   a, b : block operands
//   ci   : carry into bit 0 of the block
//   s    : block sum
//   co   : carry out of the top bit of the block
// ---------------------------------------------------------------------------
module cla_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK-1:0] g;
  logic [BLK-1:0] p;
  logic [BLK:0]   c;
  logic           term;
  logic           acc;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is built as a flat sum of products over generate/propagate
  // terms and the block carry-in, so no carry depends on another carry:
  //   c[i] = ci&p[0..i-1] | g[0]&p[1..i-1] | ... | g[i-1]
  always_comb begin
    c    = '0;
    term = 1'b0;
    acc  = 1'b0;
    for (int i = 0; i <= BLK; i++) begin
      acc = ci;
      for (int k = 0; k < i; k++) begin
        acc = acc & p[k];
      end
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        acc = acc | term;
      end
      c[i] = acc;
    end
  end

  assign s  = p ^ c[BLK-1:0];
  assign co = c[BLK];

endmodule

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
// Pipelined add/subtract unit; one BLK-bit lookahead block is resolved per
// stage, with a valid/ready handshake and a single global advance enable.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake
//   x, y, cin, sub      : operands, carry-in, mode (1 = x - y)
//   out_valid/out_ready : result handshake
//   z, cout, ovf        : result, carry out (no-borrow for sub), signed ovf
// ---------------------------------------------------------------------------
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int BLK   = CLA_BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int S  = claStages(WIDTH, BLK);
  localparam int NB = S - 1;

  if (((WIDTH % BLK) != 0) || (WIDTH < BLK)) begin : gBadParams
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of BLK");
  end

  logic             en;
  logic [WIDTH-1:0] a_q [0:NB-1];
  logic [WIDTH-1:0] a_d [0:NB-1];
  logic [WIDTH-1:0] b_q [0:NB-1];
  logic [WIDTH-1:0] b_d [0:NB-1];
  logic [WIDTH-1:0] s_q [1:NB];
  logic [WIDTH-1:0] s_d [1:NB];
  logic [NB:0]      c_q;
  logic [NB:0]      c_d;
  logic [NB:0]      v_q;
  logic [NB:0]      v_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [WIDTH-1:0] blkSum;
  logic [NB:1]      blkCo;

  // The whole pipe moves together; it only stalls when a finished result is
  // sitting at the output and downstream refuses it.
  assign en        = !v_q[NB] || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[NB];
  assign z         = s_q[NB];
  assign cout      = c_q[NB];
  assign ovf       = ovf_q;

  // Stage k resolves block k-1 using the carry registered by stage k-1.
  for (genvar k = 1; k <= NB; k++) begin : gStage
    cla_block #(.BLK(BLK)) uBlk (
      .a  (a_q[k-1][(k-1)*BLK +: BLK]),
      .b  (b_q[k-1][(k-1)*BLK +: BLK]),
      .ci (c_q[k-1]),
      .s  (blkSum[(k-1)*BLK +: BLK]),
      .co (blkCo[k])
    );
  end

  // Next-state for every stage. Subtraction is folded in at capture time by
  // inverting y and forcing the carry-in, so later stages only ever add.
  // Overflow uses the fact that the carry into the MSB equals a^b^s there.
  always_comb begin
    a_d[0] = x;
    b_d[0] = sub ? ~y : y;
    c_d[0] = sub ? 1'b1 : cin;
    v_d[0] = in_valid;
    for (int k = 1; k < NB; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
    end
    s_d[1] = '0;
    s_d[1][BLK-1:0] = blkSum[BLK-1:0];
    for (int k = 2; k <= NB; k++) begin
      s_d[k] = s_q[k-1];
      s_d[k][(k-1)*BLK +: BLK] = blkSum[(k-1)*BLK +: BLK];
    end
    for (int k = 1; k <= NB; k++) begin
      c_d[k] = blkCo[k];
      v_d[k] = v_q[k-1];
    end
    ovf_d = a_q[NB-1][WIDTH-1] ^ b_q[NB-1][WIDTH-1] ^ blkSum[WIDTH-1] ^ blkCo[NB];
  end

  // Reset drops every beat in flight and zeroes the visible outputs; the
  // remaining operand/partial-sum registers are don't-care until refilled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= '0;
      s_q[NB]  <= '0;
      c_q[NB]  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (en) begin
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_adder
// Scoreboard bench for cla_pipe_adder at WIDTH=16, BLK=4. Stimulus pushes the
// expected result of each accepted beat; a monitor pops on every output
// transfer and compares value and (where the pipe never stalls) latency.
// ---------------------------------------------------------------------------
module tb_cla_pipe_adder;

  typedef struct {
    logic [15:0] z;
    logic        cout;
    logic        ovf;
    int          issueCyc;
    bit          chkLat;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;
  logic        cout;
  logic        ovf;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  cla_pipe_adder #(.WIDTH(16), .BLK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: plain unsigned sum/difference for z and cout,
  // true signed result range test for overflow.
  function automatic expT refModel(input logic [15:0] ax, input logic [15:0] ay,
                                   input logic acin, input logic asub);
    expT         e;
    int unsigned sum;
    int          sx;
    int          sy;
    int          r;
    sx = int'($signed(ax));
    sy = int'($signed(ay));
    if (asub) begin
      e.z    = ax - ay;
      e.cout = (ax >= ay);
      r      = sx - sy;
    end else begin
      sum    = int'(ax) + int'(ay) + int'(acin);
      e.z    = sum[15:0];
      e.cout = (sum > 32'd65535);
      r      = sx + sy + int'(acin);
    end
    e.ovf      = (r > 32767) || (r < -32768);
    e.issueCyc = 0;
    e.chkLat   = 1'b0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Drive one beat and hold it until accepted, then record its expectation.
  task automatic applyStimulus(input logic [15:0] ax, input logic [15:0] ay,
                               input logic acin, input logic asub,
                               input expT e, input bit chkLat);
    int guard;
    @(negedge clk);
    x = ax; y = ay; cin = acin; sub = asub; in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready) begin
      if (guard > 50) begin
        $display("[TB] FAIL accept_timeout: in_ready stuck at 0, expected 1");
        $fatal(1, "[TB] stopping");
      end
      @(negedge clk);
      #1;
      guard++;
    end
    e.issueCyc = cyc;
    e.chkLat   = chkLat;
    expQ.push_back(e);
  endtask

  task automatic applyRandom(input bit chkLat);
    logic [15:0] rx;
    logic [15:0] ry;
    logic        rc;
    logic        rs;
    rx = 16'($urandom);
    ry = 16'($urandom);
    rc = 1'($urandom_range(0, 1));
    rs = 1'($urandom_range(0, 1));
    applyStimulus(rx, ry, rc, rs, refModel(rx, ry, rc, rs), chkLat);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  function automatic expT mkExp(input logic [15:0] ez, input logic ec, input logic eo);
    expT e;
    e.z = ez; e.cout = ec; e.ovf = eo; e.issueCyc = 0; e.chkLat = 1'b0;
    return e;
  endfunction

  // Monitor: values are read at the edge, before the DUT's updates land, so
  // out_valid && out_ready here is exactly the output transfer.
  always @(posedge clk) begin
    expT e;
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output: got z=0x%0h with no beat pending", z);
      end else begin
        e = expQ.pop_front();
        checkOutput("z", int'(z), int'(e.z));
        checkOutput("cout", int'(cout), int'(e.cout));
        checkOutput("ovf", int'(ovf), int'(e.ovf));
        if (e.chkLat) checkOutput("latency", cyc - e.issueCyc, 5);
      end
    end
    cyc++;
  end

  // Directed corners, random streaming, back-pressure, mid-flight reset and
  // sparse input, then a final drain check.
  initial begin
    int guard;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_z", int'(z), 0);
    checkOutput("rst_cout", int'(cout), 0);
    checkOutput("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", int'(in_ready), 1);

    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, mkExp(16'h0000, 1'b1, 1'b0), 1'b1);
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, mkExp(16'hFFFE, 1'b0, 1'b0), 1'b1);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, mkExp(16'h8000, 1'b0, 1'b1), 1'b1);
    applyStimulus(16'h0000, 16'h8000, 1'b1, 1'b1, mkExp(16'h8000, 1'b0, 1'b1), 1'b1);
    idleCycles(8);

    for (int i = 0; i < 100; i++) applyRandom(1'b1);
    idleCycles(8);

    for (int i = 0; i < 5; i++) applyRandom(1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checkOutput("stall_out_valid", int'(out_valid), 1);
    out_ready = 1'b0;
    x = 16'h4321; y = 16'h1234; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_in_ready", int'(in_ready), 0);
      checkOutput("stall_z", int'(z), int'(expQ[0].z));
      checkOutput("stall_cout", int'(cout), int'(expQ[0].cout));
      checkOutput("stall_ovf", int'(ovf), int'(expQ[0].ovf));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", int'(in_ready), 1);
    expQ.push_back(refModel(16'h4321, 16'h1234, 1'b1, 1'b0));
    idleCycles(10);
    checkOutput("stall_drain", expQ.size(), 0);

    for (int i = 0; i < 3; i++) applyRandom(1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("flush_out_valid", int'(out_valid), 0);
    checkOutput("flush_z", int'(z), 0);
    checkOutput("flush_cout", int'(cout), 0);
    checkOutput("flush_ovf", int'(ovf), 0);
    checkOutput("flush_in_ready", int'(in_ready), 1);
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, mkExp(16'h2345, 1'b0, 1'b0), 1'b1);
    idleCycles(10);

    for (int i = 0; i < 20; i++) begin
      applyRandom(1'b1);
      idleCycles(1);
    end
    idleCycles(10);
    checkOutput("final_drain", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
